// File: rtl/vme_multiwin_decoder_if.sv
// VME core <-> decoder bus bundle.
//   master : VME core side (drives address, write data, strobes)
//   slave  : decoder side (returns read data and completions)
// Ports carried: VMEAddr[ADDR_W:1], VMEWrData, VMERdMem, VMEWrMem,
//                VMERdData, VMERdDone, VMEWrDone.
interface vme_multiwin_decoder_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic [ADDR_W:1]   VMEAddr;
  logic [DATA_W-1:0] VMEWrData;
  logic              VMERdMem;
  logic              VMEWrMem;
  logic [DATA_W-1:0] VMERdData;
  logic              VMERdDone;
  logic              VMEWrDone;

  modport master (
    output VMEAddr, VMEWrData, VMERdMem, VMEWrMem,
    input  VMERdData, VMERdDone, VMEWrDone
  );

  modport slave (
    input  VMEAddr, VMEWrData, VMERdMem, VMEWrMem,
    output VMERdData, VMERdDone, VMEWrDone
  );
endinterface

// File: rtl/vme_multiwin_decoder.sv
// VME slave address decoder fanning out to N_WIN memory windows plus a
// control/status register page (CTRL word 0, STATUS word 1).
// Ports:
//   Clk, Rst            clock, synchronous active-high reset
//   vme                 VME core bus (slave modport)
//   win_*_o / win_*_i   per-window address, write data, strobes, read data, acks
//   softReset_reset_o   CTRL bit 0
//   timeout_irq_o       registered OR of the sticky timeout bits
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | accepts a strobe; register/unmapped accesses finish here
// RD_WAIT | window read outstanding, waiting for ack or timeout
// WR_WAIT | window write outstanding, waiting for ack or timeout
module vme_multiwin_decoder #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int N_WIN   = 4,
  parameter int WIN_AW  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                      Clk,
  input  logic                      Rst,
  vme_multiwin_decoder_if.slave     vme,
  output logic [N_WIN*WIN_AW-1:0]   win_VMEAddr_o,
  output logic [DATA_W-1:0]         win_VMEWrData_o,
  output logic [N_WIN-1:0]          win_VMERdMem_o,
  output logic [N_WIN-1:0]          win_VMEWrMem_o,
  input  logic [N_WIN*DATA_W-1:0]   win_VMERdData_i,
  input  logic [N_WIN-1:0]          win_VMERdDone_i,
  input  logic [N_WIN-1:0]          win_VMEWrDone_i,
  output logic                      softReset_reset_o,
  output logic                      timeout_irq_o
);
  localparam int K_W   = $clog2(N_WIN);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:1] REG_CTRL = (ADDR_W-1)'(0);
  localparam logic [ADDR_W-1:1] REG_STAT = (ADDR_W-1)'(1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t              state_q, state_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [WIN_AW-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ctrl_q, ctrl_d;
  logic [N_WIN-1:0]    sticky_q, sticky_d;
  logic                ovr_q, ovr_d;
  logic                rd_done_q, rd_done_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                irq_q, irq_d;
  logic                wr_stb_q, wr_stb_d;
  logic [ADDR_W:1]     wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;

  logic                wr_done;
  logic [N_WIN-1:0]    win_rd, win_wr;
  logic [N_WIN-1:0]    sticky_set, sticky_clr;
  logic                ovr_set, ovr_clr;
  logic [DATA_W-1:0]   reg_rd;
  logic [K_W-1:0]      rd_k, wr_k;

  assign rd_k = vme.VMEAddr[ADDR_W-1 -: K_W];
  assign wr_k = wr_addr_q[ADDR_W-1 -: K_W];

  // Register page read mux, addressed by the live (unregistered) read address.
  always_comb begin
    reg_rd = '0;
    if (vme.VMEAddr[ADDR_W-1:1] == REG_CTRL) begin
      reg_rd[0] = ctrl_q;
    end else if (vme.VMEAddr[ADDR_W-1:1] == REG_STAT) begin
      reg_rd[N_WIN:0] = {ovr_q, sticky_q};
    end
  end

  always_comb begin
    // A write that coincides with a read is dropped before it is registered.
    wr_stb_d   = vme.VMEWrMem & ~vme.VMERdMem;
    wr_addr_d  = vme.VMEAddr;
    wr_data_d  = vme.VMEWrData;
    state_d    = state_q;
    k_d        = k_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    ctrl_d     = ctrl_q;
    rd_done_d  = 1'b0;
    rd_data_d  = '0;
    wr_done    = 1'b0;
    win_rd     = '0;
    win_wr     = '0;
    sticky_set = '0;
    sticky_clr = '0;
    ovr_set    = vme.VMERdMem & vme.VMEWrMem;
    ovr_clr    = 1'b0;

    case (state_q)
      IDLE: begin
        if (wr_stb_q) begin
          // The registered write is older than a fresh read strobe, so it wins.
          if (vme.VMERdMem) ovr_set = 1'b1;
          if (!wr_addr_q[ADDR_W]) begin
            win_wr[wr_k] = 1'b1;
            k_d          = wr_k;
            addr_d       = wr_addr_q[WIN_AW:1];
            cnt_d        = CNT_LOAD;
            state_d      = WR_WAIT;
          end else begin
            wr_done = 1'b1;
            if (wr_addr_q[ADDR_W-1:1] == REG_CTRL) begin
              ctrl_d = wr_data_q[0];
            end else if (wr_addr_q[ADDR_W-1:1] == REG_STAT) begin
              sticky_clr = wr_data_q[N_WIN-1:0];
              ovr_clr    = wr_data_q[N_WIN];
            end
          end
        end else if (vme.VMERdMem) begin
          if (!vme.VMEAddr[ADDR_W]) begin
            win_rd[rd_k] = 1'b1;
            k_d          = rd_k;
            addr_d       = vme.VMEAddr[WIN_AW:1];
            cnt_d        = CNT_LOAD;
            state_d      = RD_WAIT;
          end else begin
            rd_done_d = 1'b1;
            rd_data_d = reg_rd;
          end
        end
      end
      RD_WAIT: begin
        if (vme.VMERdMem || wr_stb_q) ovr_set = 1'b1;
        if (win_VMERdDone_i[k_q]) begin
          rd_done_d = 1'b1;
          rd_data_d = win_VMERdData_i[k_q*DATA_W +: DATA_W];
          state_d   = IDLE;
        end else if (cnt_q == '0) begin
          rd_done_d     = 1'b1;
          rd_data_d     = '1;
          sticky_set[k_q] = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WR_WAIT: begin
        if (vme.VMERdMem || wr_stb_q) ovr_set = 1'b1;
        if (win_VMEWrDone_i[k_q]) begin
          wr_done = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          wr_done         = 1'b1;
          sticky_set[k_q] = 1'b1;
          state_d         = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Set has priority over a same-cycle write-1-to-clear.
    sticky_d = (sticky_q & ~sticky_clr) | sticky_set;
    ovr_d    = (ovr_q & ~ovr_clr) | ovr_set;
    irq_d    = |sticky_q;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      ctrl_q    <= 1'b0;
      sticky_q  <= '0;
      ovr_q     <= 1'b0;
      rd_done_q <= 1'b0;
      rd_data_q <= '0;
      irq_q     <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      sticky_q  <= sticky_d;
      ovr_q     <= ovr_d;
      rd_done_q <= rd_done_d;
      rd_data_q <= rd_data_d;
      irq_q     <= irq_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Outstanding window sees the latched address; a window being strobed for a
  // write sees the registered address that goes with the registered data.
  for (genvar g = 0; g < N_WIN; g++) begin : g_win_addr
    assign win_VMEAddr_o[g*WIN_AW +: WIN_AW] =
      Rst                                    ? '0 :
      (state_q != IDLE && k_q == K_W'(g))    ? addr_q :
      win_wr[g]                              ? wr_addr_q[WIN_AW:1] :
                                               vme.VMEAddr[WIN_AW:1];
  end

  assign win_VMEWrData_o   = wr_data_q;
  assign win_VMERdMem_o    = win_rd & {N_WIN{~Rst}};
  assign win_VMEWrMem_o    = win_wr & {N_WIN{~Rst}};
  assign vme.VMERdData     = rd_data_q;
  assign vme.VMERdDone     = rd_done_q;
  assign vme.VMEWrDone     = wr_done & ~Rst;
  assign softReset_reset_o = ctrl_q;
  assign timeout_irq_o     = irq_q;
endmodule

// File: tb/tb_vme_multiwin_decoder.sv
// Directed bench for vme_multiwin_decoder. Inputs change on the falling edge,
// outputs are sampled 1 ns later; "cycle n" is the n-th rising edge window
// after the strobe was presented.
module tb_vme_multiwin_decoder;
  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 16;
  localparam int N_WIN   = 4;
  localparam int WIN_AW  = 16;
  localparam int TIMEOUT = 8;
  localparam logic [ADDR_W-1:0] A_CTRL = 20'h80000;
  localparam logic [ADDR_W-1:0] A_STAT = 20'h80001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vme_multiwin_decoder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) vif();

  logic [N_WIN*WIN_AW-1:0] win_addr;
  logic [DATA_W-1:0]       win_wrdata;
  logic [N_WIN-1:0]        win_rdmem, win_wrmem, win_rddone, win_wrdone;
  logic [N_WIN*DATA_W-1:0] win_rddata;
  logic                    soft_rst, irq;

  int checks = 0;
  int errors = 0;

  vme_multiwin_decoder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_WIN(N_WIN),
    .WIN_AW(WIN_AW), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk              (clk),
    .Rst              (rst),
    .vme              (vif),
    .win_VMEAddr_o    (win_addr),
    .win_VMEWrData_o  (win_wrdata),
    .win_VMERdMem_o   (win_rdmem),
    .win_VMEWrMem_o   (win_wrmem),
    .win_VMERdData_i  (win_rddata),
    .win_VMERdDone_i  (win_rddone),
    .win_VMEWrDone_i  (win_wrdone),
    .softReset_reset_o(soft_rst),
    .timeout_irq_o    (irq)
  );

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic reg_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           output logic done);
    @(negedge clk);
    vif.VMEAddr = a; vif.VMEWrData = d; vif.VMEWrMem = 1'b1;
    @(negedge clk);
    vif.VMEWrMem = 1'b0;
    #1 done = vif.VMEWrDone;
  endtask

  task automatic reg_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] data,
                          output logic done);
    @(negedge clk);
    vif.VMEAddr = a; vif.VMERdMem = 1'b1;
    @(negedge clk);
    vif.VMERdMem = 1'b0;
    #1 begin data = vif.VMERdData; done = vif.VMERdDone; end
  endtask

  task automatic test_reset();
    logic [DATA_W-1:0] d;
    logic dn;
    rst = 1'b1;
    vif.VMEAddr = '0; vif.VMEWrData = '0; vif.VMERdMem = 1'b0; vif.VMEWrMem = 1'b0;
    win_rddone = '0; win_wrdone = '0;
    win_rddata = {16'h3333, 16'hBEEF, 16'h1111, 16'h5A5A};
    repeat (3) @(negedge clk);
    #1;
    checks++; if (vif.VMEWrDone !== 1'b0) begin errors++; $display("FAIL rst_wrdone got %b exp 0", vif.VMEWrDone); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (vif.VMERdDone !== 1'b0) begin errors++; $display("FAIL rst_rddone got %b exp 0", vif.VMERdDone); end
    checks++; if (soft_rst !== 1'b0) begin errors++; $display("FAIL rst_soft got %b exp 0", soft_rst); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", irq); end
    checks++; if (win_rdmem !== 4'b0 || win_wrmem !== 4'b0) begin errors++; $display("FAIL rst_strobes got %b/%b exp 0/0", win_rdmem, win_wrmem); end
    checks++; if (win_wrdata !== 16'h0) begin errors++; $display("FAIL rst_wrdata got %h exp 0000", win_wrdata); end
    reg_read(A_STAT, d, dn);
    checks++; if (dn !== 1'b1 || d !== 16'h0000) begin errors++; $display("FAIL rst_status got done=%b %h exp done=1 0000", dn, d); end
  endtask

  task automatic test_ctrl();
    logic [DATA_W-1:0] d;
    logic dn;
    @(negedge clk);
    vif.VMEAddr = A_CTRL; vif.VMEWrData = 16'h0001; vif.VMEWrMem = 1'b1;
    #1;
    checks++; if (vif.VMEWrDone !== 1'b0) begin errors++; $display("FAIL ctrl_wr_c0 got %b exp 0", vif.VMEWrDone); end
    @(negedge clk);
    vif.VMEWrMem = 1'b0;
    #1;
    checks++; if (vif.VMEWrDone !== 1'b1) begin errors++; $display("FAIL ctrl_wr_c1 got %b exp 1", vif.VMEWrDone); end
    checks++; if (soft_rst !== 1'b0) begin errors++; $display("FAIL ctrl_soft_c1 got %b exp 0", soft_rst); end
    @(negedge clk);
    #1;
    checks++; if (vif.VMEWrDone !== 1'b0) begin errors++; $display("FAIL ctrl_wr_c2 got %b exp 0", vif.VMEWrDone); end
    checks++; if (soft_rst !== 1'b1) begin errors++; $display("FAIL ctrl_soft_c2 got %b exp 1", soft_rst); end
    @(negedge clk);
    vif.VMEAddr = A_CTRL; vif.VMERdMem = 1'b1;
    #1;
    checks++; if (vif.VMERdDone !== 1'b0 || win_rdmem !== 4'b0) begin errors++; $display("FAIL ctrl_rd_c0 got done=%b rdmem=%b exp 0/0", vif.VMERdDone, win_rdmem); end
    @(negedge clk);
    vif.VMERdMem = 1'b0;
    #1;
    checks++; if (vif.VMERdDone !== 1'b1 || vif.VMERdData !== 16'h0001) begin errors++; $display("FAIL ctrl_rd_c1 got done=%b %h exp 1 0001", vif.VMERdDone, vif.VMERdData); end
    reg_read(A_STAT, d, dn);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL ctrl_status got %h exp 0000", d); end
  endtask

  task automatic test_window_read();
    @(negedge clk);
    vif.VMEAddr = 20'h41234; vif.VMERdMem = 1'b1;
    #1;
    checks++; if (win_rdmem !== 4'b0100) begin errors++; $display("FAIL wrd_strobe got %b exp 0100", win_rdmem); end
    checks++; if (win_addr[2*WIN_AW +: WIN_AW] !== 16'h1234) begin errors++; $display("FAIL wrd_addr_c0 got %h exp 1234", win_addr[2*WIN_AW +: WIN_AW]); end
    @(negedge clk);
    vif.VMERdMem = 1'b0; vif.VMEAddr = 20'h00ABC;
    #1;
    checks++; if (win_rdmem !== 4'b0000) begin errors++; $display("FAIL wrd_strobe_c1 got %b exp 0000", win_rdmem); end
    checks++; if (win_addr[2*WIN_AW +: WIN_AW] !== 16'h1234) begin errors++; $display("FAIL wrd_addr_held got %h exp 1234", win_addr[2*WIN_AW +: WIN_AW]); end
    checks++; if (win_addr[0 +: WIN_AW] !== 16'h0ABC) begin errors++; $display("FAIL wrd_addr_live0 got %h exp 0abc", win_addr[0 +: WIN_AW]); end
    @(negedge clk);
    @(negedge clk);
    win_rddone = 4'b0100;
    #1;
    checks++; if (vif.VMERdDone !== 1'b0 || win_addr[2*WIN_AW +: WIN_AW] !== 16'h1234) begin errors++; $display("FAIL wrd_ack_cycle got done=%b addr=%h exp 0 1234", vif.VMERdDone, win_addr[2*WIN_AW +: WIN_AW]); end
    @(negedge clk);
    win_rddone = 4'b0000;
    #1;
    checks++; if (vif.VMERdDone !== 1'b1 || vif.VMERdData !== 16'hBEEF) begin errors++; $display("FAIL wrd_data got done=%b %h exp 1 beef", vif.VMERdDone, vif.VMERdData); end
    @(negedge clk);
    #1;
    checks++; if (vif.VMERdDone !== 1'b0) begin errors++; $display("FAIL wrd_done_pulse got %b exp 0", vif.VMERdDone); end
  endtask

  task automatic test_write_timeout();
    logic [DATA_W-1:0] d;
    logic dn;
    int early = 0;
    @(negedge clk);
    vif.VMEAddr = 20'h20055; vif.VMEWrData = 16'hA5A5; vif.VMEWrMem = 1'b1;
    @(negedge clk);
    vif.VMEWrMem = 1'b0;
    #1;
    checks++; if (win_wrmem !== 4'b0010 || win_wrdata !== 16'hA5A5) begin errors++; $display("FAIL wto_strobe got %b %h exp 0010 a5a5", win_wrmem, win_wrdata); end
    checks++; if (win_addr[1*WIN_AW +: WIN_AW] !== 16'h0055) begin errors++; $display("FAIL wto_addr got %h exp 0055", win_addr[1*WIN_AW +: WIN_AW]); end
    for (int c = 1; c <= TIMEOUT; c++) begin
      if (c > 1) begin @(negedge clk); #1; end
      if (vif.VMEWrDone === 1'b1) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL wto_early got %0d done cycles exp 0", early); end
    @(negedge clk);
    #1;
    checks++; if (vif.VMEWrDone !== 1'b1) begin errors++; $display("FAIL wto_done got %b exp 1 at cycle %0d", vif.VMEWrDone, TIMEOUT + 1); end
    @(negedge clk);
    #1;
    checks++; if (vif.VMEWrDone !== 1'b0) begin errors++; $display("FAIL wto_done_pulse got %b exp 0", vif.VMEWrDone); end
    @(negedge clk);
    #1;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL wto_irq got %b exp 1", irq); end
    reg_read(A_STAT, d, dn);
    checks++; if (dn !== 1'b1 || d !== 16'h0002) begin errors++; $display("FAIL wto_status got done=%b %h exp 1 0002", dn, d); end
    reg_write(A_STAT, 16'h0002, dn);
    checks++; if (dn !== 1'b1) begin errors++; $display("FAIL wto_clr_done got %b exp 1", dn); end
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL wto_irq_clr got %b exp 0", irq); end
    reg_read(A_STAT, d, dn);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL wto_status_clr got %h exp 0000", d); end
  endtask

  task automatic test_read_timeout();
    logic [DATA_W-1:0] d;
    logic dn;
    int early = 0;
    @(negedge clk);
    vif.VMEAddr = 20'h60000; vif.VMERdMem = 1'b1;
    for (int c = 1; c <= TIMEOUT; c++) begin
      @(negedge clk);
      vif.VMERdMem = 1'b0;
      #1;
      if (vif.VMERdDone === 1'b1) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL rto_early got %0d done cycles exp 0", early); end
    @(negedge clk);
    #1;
    checks++; if (vif.VMERdDone !== 1'b1 || vif.VMERdData !== 16'hFFFF) begin errors++; $display("FAIL rto_done got done=%b %h exp 1 ffff", vif.VMERdDone, vif.VMERdData); end
    reg_read(A_STAT, d, dn);
    checks++; if (d !== 16'h0008) begin errors++; $display("FAIL rto_status got %h exp 0008", d); end
    reg_write(A_STAT, 16'h0008, dn);
    reg_read(A_STAT, d, dn);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL rto_status_clr got %h exp 0000", d); end
  endtask

  task automatic test_read_expiry_ack();
    logic [DATA_W-1:0] d;
    logic dn;
    @(negedge clk);
    vif.VMEAddr = 20'h00007; vif.VMERdMem = 1'b1;
    for (int c = 1; c <= TIMEOUT; c++) begin
      @(negedge clk);
      vif.VMERdMem = 1'b0;
      win_rddone = (c == TIMEOUT) ? 4'b0001 : 4'b0000;
    end
    #1;
    checks++; if (vif.VMERdDone !== 1'b0) begin errors++; $display("FAIL exp_ack_cycle got %b exp 0", vif.VMERdDone); end
    @(negedge clk);
    win_rddone = 4'b0000;
    #1;
    checks++; if (vif.VMERdDone !== 1'b1 || vif.VMERdData !== 16'h5A5A) begin errors++; $display("FAIL exp_data got done=%b %h exp 1 5a5a", vif.VMERdDone, vif.VMERdData); end
    reg_read(A_STAT, d, dn);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL exp_status got %h exp 0000", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL exp_irq got %b exp 0", irq); end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] d;
    logic dn;
    int dones = 0;
    @(negedge clk);
    vif.VMEAddr = 20'h40010; vif.VMEWrData = 16'h1234; vif.VMEWrMem = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      vif.VMEWrMem   = (c == 2);
      vif.VMEAddr    = (c == 2) ? A_CTRL : 20'h40010;
      vif.VMEWrData  = 16'h0000;
      win_wrdone     = (c == 5) ? 4'b0100 : 4'b0000;
      #1;
      if (vif.VMEWrDone === 1'b1) dones++;
      if (c == 3) begin
        checks++; if (win_wrmem !== 4'b0000) begin errors++; $display("FAIL b2b_no_strobe got %b exp 0000", win_wrmem); end
      end
      if (c == 5) begin
        checks++; if (vif.VMEWrDone !== 1'b1) begin errors++; $display("FAIL b2b_ack_done got %b exp 1", vif.VMEWrDone); end
      end
    end
    win_wrdone = '0;
    checks++; if (dones != 1) begin errors++; $display("FAIL b2b_done_count got %0d exp 1", dones); end
    checks++; if (soft_rst !== 1'b1) begin errors++; $display("FAIL b2b_ctrl_kept got %b exp 1", soft_rst); end
    reg_read(A_STAT, d, dn);
    checks++; if (d !== 16'h0010) begin errors++; $display("FAIL b2b_overrun got %h exp 0010", d); end
    reg_write(A_STAT, 16'h0010, dn);
    reg_read(A_STAT, d, dn);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL b2b_overrun_clr got %h exp 0000", d); end
  endtask

  task automatic test_rd_wr_collision();
    logic [DATA_W-1:0] d;
    logic dn;
    @(negedge clk);
    vif.VMEAddr = A_CTRL; vif.VMEWrData = 16'h0000; vif.VMERdMem = 1'b1; vif.VMEWrMem = 1'b1;
    @(negedge clk);
    vif.VMERdMem = 1'b0; vif.VMEWrMem = 1'b0;
    #1;
    checks++; if (vif.VMERdDone !== 1'b1 || vif.VMERdData !== 16'h0001) begin errors++; $display("FAIL col_read got done=%b %h exp 1 0001", vif.VMERdDone, vif.VMERdData); end
    checks++; if (vif.VMEWrDone !== 1'b0) begin errors++; $display("FAIL col_wrdone_c1 got %b exp 0", vif.VMEWrDone); end
    @(negedge clk);
    #1;
    checks++; if (vif.VMEWrDone !== 1'b0 || soft_rst !== 1'b1) begin errors++; $display("FAIL col_write_dropped got done=%b soft=%b exp 0 1", vif.VMEWrDone, soft_rst); end
    reg_read(A_STAT, d, dn);
    checks++; if (d !== 16'h0010) begin errors++; $display("FAIL col_overrun got %h exp 0010", d); end
    reg_write(A_STAT, 16'h0010, dn);
  endtask

  task automatic test_unmapped();
    logic [DATA_W-1:0] d;
    logic dn;
    reg_write(20'h80005, 16'hFFFF, dn);
    checks++; if (dn !== 1'b1) begin errors++; $display("FAIL unm_wr_done got %b exp 1", dn); end
    reg_read(20'h80005, d, dn);
    checks++; if (dn !== 1'b1 || d !== 16'h0000) begin errors++; $display("FAIL unm_read got done=%b %h exp 1 0000", dn, d); end
    reg_read(A_CTRL, d, dn);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL unm_ctrl_kept got %h exp 0001", d); end
  endtask

  task automatic test_reset_midtx();
    logic [DATA_W-1:0] d;
    logic dn;
    int dones = 0;
    @(negedge clk);
    vif.VMEAddr = 20'h20000; vif.VMERdMem = 1'b1;
    @(negedge clk);
    vif.VMERdMem = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 3; c <= 7; c++) begin
      @(negedge clk);
      rst = 1'b0;
      win_rddone = (c == 3) ? 4'b0010 : 4'b0000;
      #1;
      if (vif.VMERdDone === 1'b1) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL mid_rst_done got %0d done cycles exp 0", dones); end
    checks++; if (soft_rst !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL mid_rst_outs got soft=%b irq=%b exp 0 0", soft_rst, irq); end
    reg_read(A_STAT, d, dn);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL mid_rst_status got %h exp 0000", d); end
    reg_read(A_CTRL, d, dn);
    checks++; if (dn !== 1'b1 || d !== 16'h0000) begin errors++; $display("FAIL mid_rst_ctrl got done=%b %h exp 1 0000", dn, d); end
  endtask

  initial begin
    test_reset();
    test_ctrl();
    test_window_read();
    test_write_timeout();
    test_read_timeout();
    test_read_expiry_ack();
    test_back_to_back();
    test_rd_wr_collision();
    test_unmapped();
    test_reset_midtx();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vme_multiwin_decoder.md
# vme_multiwin_decoder

Parametrised VME-slave address decoder for the board's top-level register map. It sits between the VME core (VMEAddr/VMERdMem/VMEWrMem strobes) and up to N_WIN memory-window sub-buses. It adds a control/status register page. Compared with the single-window decoder, it adds:
- a configurable window count;
- a latched, single-outstanding transaction engine;
- per-window ack timeout with sticky status;
- overrun detection.

## Interface
Parameters:
- ADDR_W, 20, VME word-address MSB; bus address is VMEAddr[ADDR_W:1]
- DATA_W, 16, data width
- N_WIN, 4, number of memory windows, power of two, ≥2
- WIN_AW, 16, window address MSB; requires WIN_AW ≤ ADDR_W-1-log2(N_WIN)
- TIMEOUT, 255, cycles to wait for a window ack, ≥1

Ports:
- Clk  in  1  system clock
- Rst  in  1  reset; synchronous, active-high
- VMEAddr  in  ADDR_W  word address [ADDR_W:1]
- VMEWrData  in  DATA_W  write data
- VMERdMem / VMEWrMem  in  1 each  single-cycle read/write strobes
- VMERdData  out  DATA_W  read data, valid with VMERdDone
- VMERdDone / VMEWrDone  out  1 each  single-cycle completion
- win_VMEAddr_o  out  N_WIN*WIN_AW  per-window address [WIN_AW:1], window k in slice k
- win_VMEWrData_o  out  DATA_W  shared write data
- win_VMERdMem_o / win_VMEWrMem_o  out  N_WIN each  per-window strobes
- win_VMERdData_i  in  N_WIN*DATA_W  per-window read data
- win_VMERdDone_i / win_VMEWrDone_i  in  N_WIN each  per-window acks
- softReset_reset_o  out  1  control bit
- timeout_irq_o  out  1  OR of sticky timeout bits, registered

## Operation
Decode:
- VMEAddr[ADDR_W]=0 selects a memory window: index k = VMEAddr[ADDR_W-1 : ADDR_W-log2(N_WIN)], offset = VMEAddr[WIN_AW:1].
- VMEAddr[ADDR_W]=1 selects the register page:
  - word 0 CTRL: bit0 softReset, R/W.
  - word 1 STATUS: bits[N_WIN-1:0] timeout sticky per window, bit N_WIN overrun sticky; write-1-to-clear; unused bits read 0.
  - Other words are unmapped: writes are ignored, reads return 0; both are acked.

FSM states:
- IDLE: accepts a strobe.
- RD_WAIT / WR_WAIT: window transaction outstanding; the address is latched.
- Register and unmapped accesses never leave IDLE.

Strobe rules:
- Only one transaction is outstanding at a time. A strobe arriving in RD_WAIT/WR_WAIT is dropped, sets overrun, and produces no Done.
- VMERdMem and VMEWrMem together in IDLE: the read is taken, the write is dropped, and overrun is set.

Window address and write data:
- win_VMEAddr_o slice k carries the latched address while k is outstanding, otherwise live VMEAddr offset.
- win_VMEWrData_o is the registered write data.

Timeout:
- A counter of width clog2(TIMEOUT+1) starts at the window strobe.
- If no ack arrives within TIMEOUT cycles, Done is issued anyway, sticky bit k is set, and the FSM returns to IDLE.
- Read data on timeout is all ones.
- An ack on the expiry cycle wins: no sticky bit is set.
- Sticky set and W1C in the same cycle: set wins.

Reset:
- All outputs are 0 and the FSM is IDLE; CTRL, STATUS and the counter are cleared.
- Rst mid-transaction abandons it with no Done issued; a late window ack after reset is ignored.

## Timing
Writes:
- Write inputs are registered one stage: a strobe sampled in cycle 0 is decoded in cycle 1.
- Window write: win_VMEWrMem_o[k]=1 for cycle 1 only. VMEWrDone is combinationally equal to win_VMEWrDone_i[k] while in WR_WAIT.
- Register/unmapped write: VMEWrDone=1 in cycle 1; the register takes its new value at the end of cycle 1.

Reads:
- The read strobe is decoded combinationally in cycle 0.
- Window read: win_VMERdMem_o[k]=VMERdMem in cycle 0; the address is latched at the end of cycle 0.
- Register/unmapped read: VMERdDone and VMERdData are registered, appearing in cycle 1.
- Window read completion: VMERdDone/VMERdData appear one cycle after win_VMERdDone_i[k]=1.
- Read timeout: VMERdDone is asserted in cycle TIMEOUT+1 after the strobe.

Throughput and status:
- The FSM can accept a new strobe in the cycle after Done.
- timeout_irq_o rises one cycle after a sticky bit is set.

## Test plan
- After Rst, write 0x0001 to CTRL (VMEAddr=0x80000) -> VMEWrDone in cycle 1, softReset_reset_o=1 from cycle 2; read back gives 0x0001 with VMERdDone in cycle 1.
- Read window 2 offset 0x1234 (VMEAddr=0x41234), window acks 3 cycles later with 0xBEEF -> only win_VMERdMem_o[2] pulses; address 0x1234 is held through the ack; VMERdData=0xBEEF one cycle after the ack.
- Write to window 1 with the ack never given -> VMEWrDone at cycle TIMEOUT+1, STATUS=0x0002, timeout_irq_o=1; writing 0x0002 to STATUS clears both.
- Read window 0 with the ack on exactly the expiry cycle -> real data is returned and STATUS stays 0.
- Second strobe during WR_WAIT, then the first ack -> exactly one VMEWrDone and STATUS bit N_WIN=1.
- Rst asserted in RD_WAIT, then a late window ack -> no VMERdDone; outputs and STATUS read 0.
